int2float_s: RTL and testbench

Sequential integer-to-single-precision converter for the F-extension FCVT.S.W / FCVT.S.WU path, sitting directly downstream of the `Normal32u` leading-zero normalizer. It takes a 32-bit integer, forms its magnitude, and normalizes it through an internal `Normal32u` instance. It then rounds the normalized value to 24 significant bits according to the RISC-V rounding mode and packs an IEEE-754 binary32 result plus the inexact flag. Operation uses the same start/busy handshake as the other multicycle arithmetic units.

---
 rtl/int2float_s.sv | 185 ++++++++++++++++++
 tb/tb_int2float_s.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/int2float_s.sv
// int2float_s: three-step integer to IEEE-754 binary32 converter for the
// FCVT.S.W / FCVT.S.WU path. A captured operand is turned into a magnitude,
// normalized through Normal32u, then rounded to 24 significant bits under
// the RISC-V rounding mode and packed with its inexact flag.

// Normal32u: reports how far its input must be shifted left so that the
// most significant set bit lands in bit 31. A zero input reports 0; the
// caller flags the zero case separately.
module Normal32u (
    input  logic [31:0] i_a,
    output logic [4:0]  o_left_sh   // leftSh
);

    // Priority search: the highest set bit wins because it is visited last.
    always_comb begin
        o_left_sh = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (i_a[i]) begin
                o_left_sh = 5'(31 - i);
            end
        end
    end

endmodule

module int2float_s (
    input  logic        clk,
    input  logic        rstlow,
    input  logic        start,
    input  logic [31:0] a,
    input  logic        signed_op,
    input  logic [2:0]  rm,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        nx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    state_t      r_state;
    state_t      w_state_next;

    // Operands captured at the accepting edge.
    logic [31:0] r_a;
    logic        r_signed_op;
    logic [2:0]  r_rm;

    // Normalized value, bit 31 dropped: it is always 1 for a nonzero operand.
    logic [30:0] r_norm;
    logic [7:0]  r_exp;
    logic        r_zero;
    logic        r_sign;

    logic [31:0] r_result;
    logic        r_nx;

    logic        w_accept;
    logic        w_sign;
    logic [31:0] w_mag;
    logic [4:0]  w_lz;
    logic [22:0] w_frac;
    logic        w_lsb;
    logic        w_g;
    logic        w_s;
    logic        w_up;
    logic [30:0] w_sum;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // The most negative signed operand negates to itself, which read as
    // unsigned is exactly the wanted magnitude 2^31.
    assign w_sign = r_signed_op & r_a[31];
    assign w_mag  = w_sign ? (~r_a + 32'd1) : r_a;

    Normal32u u_normal32u (
        .i_a       (w_mag),
        .o_left_sh (w_lz)
    );

    // Rounding fields: 23 stored fraction bits, then guard and sticky.
    assign w_frac = r_norm[30:8];
    assign w_lsb  = r_norm[8];
    assign w_g    = r_norm[7];
    assign w_s    = |r_norm[6:0];

    // Round-up decision per rounding mode; reserved encodings fall to RNE.
    always_comb begin
        w_up = 1'b0;
        case (r_rm)
            RM_RNE:  w_up = w_g & (w_s | w_lsb);
            RM_RTZ:  w_up = 1'b0;
            RM_RDN:  w_up = r_sign & (w_g | w_s);
            RM_RUP:  w_up = ~r_sign & (w_g | w_s);
            RM_RMM:  w_up = w_g;
            default: w_up = w_g & (w_s | w_lsb);
        endcase
    end

    // Exponent and fraction added as one field so a fraction carry bumps
    // the exponent; the largest exponent is 159, so no overflow exists.
    assign w_sum = {r_exp, w_frac} + {30'd0, w_up};

    // Next-state logic for the IDLE -> NORM -> ROUND -> DONE sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_NORM;
            S_NORM:  w_state_next = S_ROUND;
            S_ROUND: w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_NORM : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstlow) begin
        if (!rstlow) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand capture on an accepted start only; starts while busy are dropped.
    always_ff @(posedge clk or negedge rstlow) begin
        if (!rstlow) begin
            r_a         <= 32'd0;
            r_signed_op <= 1'b0;
            r_rm        <= 3'd0;
        end else if (w_accept) begin
            r_a         <= a;
            r_signed_op <= signed_op;
            r_rm        <= rm;
        end
    end

    // Normalization stage: left-justify the magnitude and derive the exponent.
    always_ff @(posedge clk or negedge rstlow) begin
        if (!rstlow) begin
            r_norm <= 31'd0;
            r_exp  <= 8'd0;
            r_zero <= 1'b0;
            r_sign <= 1'b0;
        end else if (r_state == S_NORM) begin
            r_norm <= 31'(w_mag << w_lz);
            r_exp  <= 8'd158 - {3'd0, w_lz};
            r_zero <= (w_mag == 32'd0);
            r_sign <= w_sign;
        end
    end

    // Result register, updated only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rstlow) begin
        if (!rstlow) begin
            r_result <= 32'd0;
            r_nx     <= 1'b0;
        end else if (r_state == S_ROUND) begin
            if (r_zero) begin
                r_result <= 32'd0;
                r_nx     <= 1'b0;
            end else begin
                r_result <= {r_sign, w_sum};
                r_nx     <= w_g | w_s;
            end
        end
    end

    assign busy   = (r_state == S_NORM) || (r_state == S_ROUND);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign nx     = r_nx;

endmodule

// File: tb/tb_int2float_s.sv
// Bench for int2float_s: directed vector table, handshake/reset sequences,
// and random operands checked against an exact-arithmetic reference model.
module tb_int2float_s;

    logic        clk = 1'b0;
    logic        rstlow;
    logic        start;
    logic [31:0] a;
    logic        signed_op;
    logic [2:0]  rm;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        nx;

    int checks   = 0;
    int failures = 0;

    int2float_s dut (
        .clk       (clk),
        .rstlow    (rstlow),
        .start     (start),
        .a         (a),
        .signed_op (signed_op),
        .rm        (rm),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .nx        (nx)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic        so;
        logic [2:0]  rm;
        logic [31:0] exp_res;
        logic        exp_nx;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, expv);
        end
    endtask

    // Reference: exact integer arithmetic on the magnitude, rounding decided
    // by comparing the discarded remainder against half an ulp.
    function automatic void ref_conv(input logic [31:0] av, input logic so, input logic [2:0] rmv,
                                     output logic [31:0] res, output logic nxo);
        longint unsigned m, q, rem, half;
        int p, sh;
        logic sgn, up;
        sgn = so & av[31];
        m = sgn ? (64'h1_0000_0000 - 64'(av)) : 64'(av);
        res = 32'd0;
        nxo = 1'b0;
        if (m != 0) begin
            p = 0;
            for (int i = 0; i < 33; i++) if (m[i]) p = i;
            if (p <= 23) begin
                q = m << (23 - p);
                rem = 0;
                half = 0;
            end else begin
                sh = p - 23;
                q = m >> sh;
                rem = m - (q << sh);
                half = 64'd1 << (sh - 1);
            end
            nxo = (rem != 0);
            case (rmv)
                3'd1:    up = 1'b0;
                3'd2:    up = sgn && rem != 0;
                3'd3:    up = !sgn && rem != 0;
                3'd4:    up = rem != 0 && rem >= half;
                default: up = rem != 0 && (rem > half || (rem == half && q[0]));
            endcase
            q = q + 64'(up);
            if (q == (64'd1 << 24)) begin
                q = 64'd1 << 23;
                p = p + 1;
            end
            res = {sgn, 8'(127 + p), q[22:0]};
        end
    endfunction

    // One conversion with handshake timing checks; returns the DUT result.
    task automatic convert(input logic [31:0] av, input logic so, input logic [2:0] rmv,
                           output logic [31:0] res, output logic nxo);
        int n;
        @(negedge clk);
        a = av; signed_op = so; rm = rmv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; signed_op = ~so; rm = 3'($urandom_range(0, 7));
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        n = 0;
        while (!done && n < 10) begin
            @(posedge clk); #1;
            n++;
            if (!done) chk("busy_in_flight", {31'd0, busy}, 32'd1);
        end
        chk("done_latency", 32'(n), 32'd2);
        chk("busy_with_done", {31'd0, busy}, 32'd0);
        res = result;
        nxo = nx;
    endtask

    vec_t        vecs[$];
    logic [31:0] r, er;
    logic        x, ex;
    int          dcount;

    initial begin
        vecs.push_back('{"one_rne",      32'h00000001, 1'b1, 3'd0, 32'h3F800000, 1'b0});
        vecs.push_back('{"m1_signed",    32'hFFFFFFFF, 1'b1, 3'd0, 32'hBF800000, 1'b0});
        vecs.push_back('{"ones_u_rne",   32'hFFFFFFFF, 1'b0, 3'd0, 32'h4F800000, 1'b1});
        vecs.push_back('{"ones_u_rtz",   32'hFFFFFFFF, 1'b0, 3'd1, 32'h4F7FFFFF, 1'b1});
        vecs.push_back('{"minint",       32'h80000000, 1'b1, 3'd0, 32'hCF000000, 1'b0});
        vecs.push_back('{"tie_rne",      32'h01000001, 1'b0, 3'd0, 32'h4B800000, 1'b1});
        vecs.push_back('{"tie_rup",      32'h01000001, 1'b0, 3'd3, 32'h4B800001, 1'b1});
        vecs.push_back('{"tie_rmm",      32'h01000001, 1'b0, 3'd4, 32'h4B800001, 1'b1});
        vecs.push_back('{"tie_rsv7",     32'h01000001, 1'b0, 3'd7, 32'h4B800000, 1'b1});
        vecs.push_back('{"tie_odd_rne",  32'h01000003, 1'b0, 3'd0, 32'h4B800002, 1'b1});
        vecs.push_back('{"neg_rdn",      32'hFEFFFFFF, 1'b1, 3'd2, 32'hCB800001, 1'b1});
        vecs.push_back('{"neg_rtz",      32'hFEFFFFFF, 1'b1, 3'd1, 32'hCB800000, 1'b1});
        vecs.push_back('{"neg_rup",      32'hFEFFFFFF, 1'b1, 3'd3, 32'hCB800000, 1'b1});
        vecs.push_back('{"zero_s_rup",   32'h00000000, 1'b1, 3'd3, 32'h00000000, 1'b0});
        vecs.push_back('{"zero_u_rdn",   32'h00000000, 1'b0, 3'd2, 32'h00000000, 1'b0});
        vecs.push_back('{"seven",        32'h00000007, 1'b0, 3'd1, 32'h40E00000, 1'b0});

        rstlow = 1'b0; start = 1'b0; a = 32'd0; signed_op = 1'b0; rm = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy",   {31'd0, busy}, 32'd0);
        chk("reset_done",   {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_nx",     {31'd0, nx}, 32'd0);
        @(negedge clk);
        rstlow = 1'b1;

        // Directed vector table.
        foreach (vecs[i]) begin
            convert(vecs[i].a, vecs[i].so, vecs[i].rm, r, x);
            chk({vecs[i].name, "_result"}, r, vecs[i].exp_res);
            chk({vecs[i].name, "_nx"}, {31'd0, x}, {31'd0, vecs[i].exp_nx});
            $display("vec %-12s a=%h so=%0d rm=%0d -> result=%h nx=%0d",
                     vecs[i].name, vecs[i].a, vecs[i].so, vecs[i].rm, r, x);
        end

        // Start pulsed while busy must be ignored.
        @(negedge clk);
        a = 32'd1; signed_op = 1'b1; rm = 3'd0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); a = 32'd5; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("busystart_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        chk("busystart_done", {31'd0, done}, 32'd1);
        chk("busystart_result", result, 32'h3F800000);
        @(posedge clk); #1;
        chk("busystart_pulse_end", {31'd0, done}, 32'd0);
        chk("busystart_no_relaunch", {31'd0, busy}, 32'd0);
        $display("seq busy_start result=%h", result);

        // Back-to-back: start held through DONE is accepted there.
        @(negedge clk);
        a = 32'd1; signed_op = 1'b1; rm = 3'd0; start = 1'b1;
        @(posedge clk); #1; a = 32'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("b2b_first_done", {31'd0, done}, 32'd1);
        chk("b2b_first_result", result, 32'h3F800000);
        @(negedge clk); a = 32'hFFFFFFFF;
        @(posedge clk); #1; start = 1'b0;
        chk("b2b_done_low", {31'd0, done}, 32'd0);
        chk("b2b_busy_again", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("b2b_second_done", {31'd0, done}, 32'd1);
        chk("b2b_second_result", result, 32'hBF800000);
        $display("seq back_to_back result=%h", result);

        // Reset during ROUND aborts without a done pulse.
        @(negedge clk);
        a = 32'd3; signed_op = 1'b0; rm = 3'd0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_round", {31'd0, busy}, 32'd1);
        @(negedge clk); rstlow = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_result", result, 32'd0);
        @(negedge clk); rstlow = 1'b1;
        dcount = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("abort_no_done", 32'(dcount), 32'd0);
        chk("abort_result_held", result, 32'd0);
        convert(32'd7, 1'b0, 3'd0, r, x);
        chk("after_reset_result", r, 32'h40E00000);
        $display("seq reset_abort then result=%h", r);

        // Random operands against the reference model.
        for (int i = 0; i < 150; i++) begin
            logic [31:0] av;
            logic        so;
            logic [2:0]  rmv;
            av  = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) av = ~av + 32'd1;
            so  = 1'($urandom_range(0, 1));
            rmv = 3'($urandom_range(0, 7));
            ref_conv(av, so, rmv, er, ex);
            convert(av, so, rmv, r, x);
            chk("rand_result", r, er);
            chk("rand_nx", {31'd0, x}, {31'd0, ex});
            $display("rand a=%h so=%0d rm=%0d -> result=%h nx=%0d (model %h %0d)",
                     av, so, rmv, r, x, er, ex);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
